// File: rtl/vgaconsole_glyph_sequencer.sv
// Per-scanline text fetch scheduler: text RAM -> char ROM -> serial glyph pixels.
// Optional blinking cell cursor when VGACONSOLE_CURSOR_EN is defined.
module vgaconsole_glyph_sequencer #(
    parameter int COLS    = 10,
    parameter int ROWS    = 4,
    parameter int GLYPH_W = 5,
    parameter int GLYPH_H = 7,
    parameter int CELL_W  = 6,
    parameter int CELL_H  = 8,
    parameter int AW      = $clog2(COLS*ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_en,
    input  logic                       frame_start,
    input  logic                       line_start,
    input  logic                       de,
    output logic [AW-1:0]              txt_addr,
    input  logic [6:0]                 txt_data,
    output logic [6:0]                 rom_addr,
    input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
`ifdef VGACONSOLE_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]    cursor_col,
    input  logic [$clog2(ROWS)-1:0]    cursor_row,
`endif
    output logic                       pixel
);
    localparam int RW = $clog2(ROWS+1);
    localparam int LW = $clog2(CELL_H);
    localparam int CW = $clog2(COLS+1);
    localparam int PW = $clog2(CELL_W);
    localparam logic [RW-1:0] ROW_END   = RW'(ROWS);
    localparam logic [LW-1:0] LINE_LAST = LW'(CELL_H-1);
    localparam logic [CW-1:0] COLS_M1   = CW'(COLS-1);
    localparam logic [PW-1:0] PX_LAST   = PW'(CELL_W-1);

    typedef enum logic [2:0] {IDLE, PREFETCH, READY, ACTIVE, DONE} state_t;

    state_t               state;
    logic [RW-1:0]        text_row, row_n;
    logic [LW-1:0]        cell_line, line_n;
    logic                 first, first_n;
    logic [CW-1:0]        col;
    logic [PW-1:0]        px;
    logic [1:0]           fstep;
    logic [GLYPH_W-1:0]   next_bits, shift, slice, start_bits;
    logic                 go, fetch_done, line_blank, cur, glyph_px;

`ifdef VGACONSOLE_CURSOR_EN
    localparam bit CURSOR = 1'b1;
    logic [4:0] frame_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 1'b1;
    end
    assign cur = frame_cnt[4] && (text_row == RW'(cursor_row)) && (col == CW'(cursor_col));
`else
    localparam bit CURSOR = 1'b0;
    assign cur = 1'b0;
`endif

    // frame_start is folded in before line_start so a coincident pair lands on line 0
    always_comb begin
        row_n   = text_row;
        line_n  = cell_line;
        first_n = first;
        if (frame_start) begin
            row_n   = '0;
            line_n  = '0;
            first_n = 1'b1;
        end
        if (line_start) begin
            if (first_n) first_n = 1'b0;
            else if (line_n == LINE_LAST) begin
                line_n = '0;
                if (row_n != ROW_END) row_n = row_n + 1'b1;
            end else line_n = line_n + 1'b1;
        end
    end

    // Gap scanlines only need rendering when the cursor can paint them
    assign line_blank = (row_n >= ROW_END) || (!CURSOR && (line_n >= LW'(GLYPH_H)));

    always_comb begin
        slice = '0;
        for (int i = 0; i < GLYPH_H; i++)
            if (cell_line == LW'(i)) slice = rom_data[i*GLYPH_W +: GLYPH_W];
    end

    assign fetch_done = (fstep == 2'd3);
    // A pixel arriving on the very clk the first fetch lands takes the ROM slice directly
    assign go         = pix_en && de && ((state == READY) || ((state == PREFETCH) && fetch_done));
    assign start_bits = (state == READY) ? next_bits : slice;
    assign glyph_px   = (px < PW'(GLYPH_W)) ? shift[px] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            text_row  <= '0;
            cell_line <= '0;
            first     <= 1'b1;
            col       <= '0;
            px        <= '0;
            fstep     <= 2'd0;
            next_bits <= '0;
            shift     <= '0;
            txt_addr  <= '0;
            rom_addr  <= '0;
            pixel     <= 1'b0;
        end else begin
            text_row  <= row_n;
            cell_line <= line_n;
            first     <= first_n;
            // fetch pipe: addr out -> RAM data -> ROM addr -> slice captured
            case (fstep)
                2'd1: fstep <= 2'd2;
                2'd2: begin rom_addr <= txt_data; fstep <= 2'd3; end
                2'd3: begin next_bits <= slice; fstep <= 2'd0; end
                default: ;
            endcase
            if (line_start) begin
                col   <= '0;
                px    <= '0;
                pixel <= 1'b0;
                if (line_blank) begin
                    state <= IDLE;
                    fstep <= 2'd0;
                end else begin
                    state    <= PREFETCH;
                    txt_addr <= AW'(row_n * COLS);
                    fstep    <= 2'd1;
                end
            end else begin
                case (state)
                    PREFETCH, READY: begin
                        pixel <= 1'b0;
                        if (go) begin
                            shift <= start_bits;
                            pixel <= start_bits[0] ^ cur;
                            px    <= PW'(1);
                            state <= ACTIVE;
                            if (COLS > 1) begin
                                txt_addr <= AW'(text_row * COLS) + AW'(1);
                                fstep    <= 2'd1;
                            end
                        end else if (fetch_done) state <= READY;
                    end
                    ACTIVE: begin
                        if (!de) begin
                            state <= DONE;
                            pixel <= 1'b0;
                        end else if (pix_en) begin
                            pixel <= glyph_px ^ cur;
                            if ((px == '0) && (col < COLS_M1)) begin
                                txt_addr <= AW'(text_row * COLS) + AW'(col) + AW'(1);
                                fstep    <= 2'd1;
                            end
                            if (px == PX_LAST) begin
                                px    <= '0;
                                col   <= col + 1'b1;
                                shift <= next_bits;
                                if (col == COLS_M1) state <= DONE;
                            end else px <= px + 1'b1;
                        end
                    end
                    default: pixel <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vgaconsole_glyph_sequencer.sv
// Randomized bench: scanline/pixel-index reference model of the text console.
module tb_vgaconsole_glyph_sequencer;
    localparam int COLS = 10, ROWS = 4, GLYPH_W = 5, GLYPH_H = 7, CELL_W = 6, CELL_H = 8;
    localparam int AW = $clog2(COLS*ROWS);

    logic clk = 1'b0, rst_n = 1'b0;
    logic pix_en = 1'b0, frame_start = 1'b0, line_start = 1'b0, de = 1'b0;
    logic [AW-1:0] txt_addr;
    logic [6:0] txt_data = '0, rom_addr;
    logic [34:0] rom_data;
    logic pixel;
`ifdef VGACONSOLE_CURSOR_EN
    localparam int CUR_ROW = 1, CUR_COL = 2;
    logic [1:0] cursor_row = 2'(CUR_ROW);
    logic [3:0] cursor_col = 4'(CUR_COL);
`endif

    logic [34:0] rom [128];
    logic [6:0]  ram [64];

    vgaconsole_glyph_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .frame_start(frame_start),
        .line_start(line_start), .de(de), .txt_addr(txt_addr), .txt_data(txt_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef VGACONSOLE_CURSOR_EN
        .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
        .pixel(pixel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) txt_data <= ram[txt_addr];
    assign rom_data = rom[rom_addr];

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // model: scanline index L within the frame and pixel index k within the line
    int L, k, fcnt, ls_addr, k0_addr;
    bit first, seen, ended;
    int got [80];

    function automatic int exp_px(input int line_idx, input int kk);
        int row, ln, c, x, v;
        row = line_idx / CELL_H; ln = line_idx % CELL_H;
        c = kk / CELL_W; x = kk % CELL_W; v = 0;
        if (row >= ROWS || kk >= COLS*CELL_W) return 0;
        if (x < GLYPH_W && ln < GLYPH_H) v = int'(rom[ram[row*COLS + c]][ln*GLYPH_W + x]);
`ifdef VGACONSOLE_CURSOR_EN
        if (row == CUR_ROW && c == CUR_COL && fcnt >= 16) v = v ^ 1;
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        bit do_chk, was_ls, counted;
        int ev, k_now;
        if (!rst_n) begin
            L = 0; first = 1; k = 0; seen = 0; ended = 1; fcnt = 0;
        end else begin
            do_chk = 0; counted = 0; ev = 0; k_now = 0; was_ls = line_start;
            if (frame_start) begin L = 0; first = 1; fcnt = (fcnt + 1) % 32; end
            if (line_start) begin
                if (first) first = 0; else L++;
                k = 0; seen = 0; ended = 0;
            end else begin
                if (pix_en) begin do_chk = 1; ev = (!ended && de) ? exp_px(L, k) : 0; end
                if (!ended) begin
                    if (de && pix_en) begin k_now = k; counted = 1; k++; seen = 1; end
                    else if (!de && seen) ended = 1;
                end
            end
            if (do_chk || was_ls) begin
                #1;
                if (was_ls) ls_addr = int'(txt_addr);
                if (do_chk) begin
                    check("pixel", int'(pixel), ev);
                    if (counted) begin
                        if (k_now < 80) got[k_now] = int'(pixel);
                        if (k_now == 0) k0_addr = int'(txt_addr);
                    end
                end
            end
        end
    end

    task automatic frame();
        frame_start = 1; @(negedge clk); frame_start = 0;
        repeat (2) @(negedge clk);
    endtask

    // mode 0: pix_en every clk, 1: alternating, 2: random (never low twice)
    task automatic do_line(input int npix, input int mode, input int rst_at, input bit abort, input bit fs);
        int n; bit pe;
        line_start = 1; frame_start = fs; de = 0; pix_en = 0;
        @(negedge clk); line_start = 0; frame_start = 0;
        repeat (3) begin pix_en = 1'($urandom_range(0, 1)); @(negedge clk); end
        n = 0; pe = 0;
        while (n < npix) begin
            if (n == rst_at) begin
                rst_n = 0; de = 0; pix_en = 0; #1;
                check("rst_mid_pixel", int'(pixel), 0);
                check("rst_mid_txt_addr", int'(txt_addr), 0);
                check("rst_mid_rom_addr", int'(rom_addr), 0);
                @(negedge clk); rst_n = 1;
                return;
            end
            case (mode)
                0: pe = 1;
                1: pe = !pe;
                default: pe = pe ? 1'($urandom_range(0, 1)) : 1'b1;
            endcase
            de = 1; pix_en = pe;
            if (pe) n++;
            @(negedge clk);
        end
        if (!abort) begin
            de = 0;
            repeat (6) begin pix_en = 1'($urandom_range(0, 1)); @(negedge clk); end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1 [6];
        t1 = '{0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 128; i++) rom[i] = 35'({$urandom(), $urandom()});
        for (int i = 0; i < 64; i++) ram[i] = 7'($urandom());
        ram[0] = 7'h41;
        rom[7'h41][4:0] = 5'b01110;

        repeat (3) @(negedge clk);
        check("reset_pixel", int'(pixel), 0);
        check("reset_txt_addr", int'(txt_addr), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        rst_n = 1; @(negedge clk);

        frame();
        do_line(66, 0, -1, 0, 0);
        for (int i = 0; i < 6; i++) check("cell0_pixel", got[i], t1[i]);
        check("cell0_first_addr", ls_addr, 0);
        check("cell0_next_addr", k0_addr, 1);

        do_line(66, 1, -1, 0, 0);
        for (int i = 2; i < 8; i++) do_line(62, 2, -1, 0, 0);
        do_line(66, 2, -1, 0, 0);
        check("row1_base_addr", ls_addr, 10);

        do_line(26, 2, -1, 1, 0);
        do_line(66, 0, -1, 0, 0);
        check("abort_restart_addr", ls_addr, 10);

        do_line(66, 0, 15, 0, 0);
        do_line(66, 1, -1, 0, 0);
        check("post_reset_addr", ls_addr, 0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 1; i < 64; i++) ram[i] = 7'($urandom());
            for (int l = 0; l < 34; l++) begin
                do_line($urandom_range(50, 70), $urandom_range(0, 2), -1, 0, l == 0);
                if (l % CELL_H == 0 && l < ROWS*CELL_H) check("row_base_addr", ls_addr, (l / CELL_H) * COLS);
            end
        end

`ifdef VGACONSOLE_CURSOR_EN
        for (int f = 0; f < 14; f++) begin
            for (int l = 0; l < 16; l++) do_line(62, $urandom_range(0, 2), -1, 0, l == 0);
            check("cursor_gap_px", got[17], (fcnt >= 16) ? 1 : 0);
            check("cursor_gap_px0", got[12], (fcnt >= 16) ? 1 : 0);
            check("cursor_neighbour", got[18], 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
